// File: rtl/id_decode_ctrl.sv
// ============================================================================
// Module      : id_decode_ctrl
// Description : Decode-stage IF/ID + ID/EX registers, immediate selection,
//               load-use bubble, flush and valid/ready back-pressure.
//               Optional macro ID_STALL_CNT_EN adds the stall_cnt counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_decode_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            id_ready,
  input  logic            flush,
  output logic [2:0]      imm_sel,
  input  logic [XLEN-1:0] imm_in,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [31:0]     ex_instr,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd,
  output logic            ex_is_load
`ifdef ID_STALL_CNT_EN
  ,
  output logic [31:0]     stall_cnt
`endif
);

  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_imm    = 7'b0010011;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_reg    = 7'b0110011;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;

  logic            r_id_valid;
  logic [31:0]     r_id_instr;
  logic [XLEN-1:0] r_id_pc;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic       w_uses_rs1;
  logic       w_uses_rs2;
  logic       w_hazard;
  logic       w_ex_adv;

  assign w_opcode = r_id_instr[6:0];
  assign w_funct3 = r_id_instr[14:12];
  assign w_rs1    = r_id_instr[19:15];
  assign w_rs2    = r_id_instr[24:20];

  always_comb begin
    imm_sel    = 3'b111;
    w_uses_rs1 = 1'b0;
    w_uses_rs2 = 1'b0;
    case (w_opcode)
      c_op_imm: begin
        w_uses_rs1 = 1'b1;
        if (w_funct3 == 3'b001)      imm_sel = 3'b101;
        else if (w_funct3 == 3'b101) imm_sel = r_id_instr[30] ? 3'b110 : 3'b101;
        else                         imm_sel = 3'b000;
      end
      c_op_load, c_op_jalr: begin
        imm_sel    = 3'b000;
        w_uses_rs1 = 1'b1;
      end
      c_op_store: begin
        imm_sel    = 3'b001;
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      c_op_branch: begin
        imm_sel    = 3'b010;
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      // R-type has no immediate; selector 111 makes the generator return zero
      c_op_reg: begin
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      c_op_lui, c_op_auipc: imm_sel = 3'b011;
      c_op_jal:             imm_sel = 3'b100;
      default:              imm_sel = 3'b111;
    endcase
  end

  assign w_hazard = r_id_valid & ex_valid & ex_is_load & (ex_rd != 5'd0) &
                    ((w_uses_rs1 & (w_rs1 == ex_rd)) | (w_uses_rs2 & (w_rs2 == ex_rd)));
  assign w_ex_adv = !ex_valid | ex_ready;
  assign id_ready = (!r_id_valid | (w_ex_adv & !w_hazard)) & !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_id_valid <= 1'b0;
      r_id_instr <= '0;
      r_id_pc    <= '0;
      ex_valid   <= 1'b0;
      ex_instr   <= '0;
      ex_pc      <= '0;
      ex_imm     <= '0;
      ex_rd      <= '0;
      ex_is_load <= 1'b0;
    end else if (flush) begin
      r_id_valid <= 1'b0;
      ex_valid   <= 1'b0;
    end else begin
      if (w_ex_adv) begin
        if (w_hazard) begin
          ex_valid <= 1'b0;
        end else begin
          ex_valid   <= r_id_valid;
          ex_instr   <= r_id_instr;
          ex_pc      <= r_id_pc;
          ex_imm     <= imm_in;
          ex_rd      <= r_id_instr[11:7];
          ex_is_load <= (w_opcode == c_op_load);
        end
      end
      // id_ready already folds in hazard and back-pressure, so IF/ID holds otherwise
      if (id_ready) begin
        r_id_valid <= if_valid;
        r_id_instr <= if_instr;
        r_id_pc    <= if_pc;
      end
    end
  end

`ifdef ID_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (!flush && w_ex_adv && w_hazard)
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_decode_ctrl.sv
// ============================================================================
// Module      : tb_id_decode_ctrl
// Description : Table-driven cycle vectors for id_decode_ctrl plus a short
//               imm_sel decode sweep; honours ID_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_decode_ctrl;

  localparam logic [31:0] c_addi = 32'h00500093;
  localparam logic [31:0] c_lw   = 32'h00012283;
  localparam logic [31:0] c_add  = 32'h00128333;
  localparam logic [31:0] c_srai = 32'h4071D193;
  localparam logic [31:0] c_slli = 32'h00109093;
  localparam logic [31:0] c_lui  = 32'h123453B7;
  localparam logic [31:0] c_jal  = 32'h0000006F;
  localparam logic [31:0] c_sw   = 32'h00112023;
  localparam logic [31:0] c_beq  = 32'h00000063;
  localparam logic [31:0] c_lw0  = 32'h00012003;
  localparam logic [31:0] c_add0 = 32'h00100333;

  logic        clk = 1'b0;
  logic        rst_n, if_valid, flush, ex_ready;
  logic [31:0] if_instr, if_pc, imm_in;
  logic        id_ready, ex_valid, ex_is_load;
  logic [2:0]  imm_sel;
  logic [31:0] ex_instr, ex_pc, ex_imm;
  logic [4:0]  ex_rd;
`ifdef ID_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  id_decode_ctrl #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .id_ready(id_ready), .flush(flush), .imm_sel(imm_sel),
    .imm_in(imm_in), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_instr(ex_instr), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load)
`ifdef ID_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  typedef struct packed {
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        flush;
    logic        ex_ready;
    logic [31:0] imm_in;
    logic        chk_comb;
    logic        e_id_ready;
    logic        chk_sel;
    logic [2:0]  e_imm_sel;
    logic        chk_data;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [31:0] e_imm;
    logic [4:0]  e_rd;
    logic        e_load;
    logic [31:0] e_stall;
  } vec_t;

  vec_t vq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d actual=0x%08h required=0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                     input logic fl, input logic er, input logic [31:0] imm,
                     input logic cc, input logic erdy, input logic cs, input logic [2:0] esel,
                     input logic cd, input logic ev, input logic [31:0] ei, input logic [31:0] ep,
                     input logic [31:0] eimm, input logic [4:0] erd, input logic eld,
                     input logic [31:0] est);
    vq.push_back('{r, iv, ins, pc, fl, er, imm, cc, erdy, cs, esel, cd, ev, ei, ep, eimm, erd, eld, est});
  endtask

  initial begin
    logic [31:0] sweep_i [5];
    logic [2:0]  sweep_s [5];

    rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0;
    flush = 1'b0; ex_ready = 1'b1; imm_in = '0;

    // reset for two cycles
    add(0,0,0,0,0,1,0,          0,0,0,3'd0, 1,0,0,0,0,0,0, 0);
    add(0,0,0,0,0,1,0,          1,1,1,3'd7, 1,0,0,0,0,0,0, 0);
    // addi, lw, add (load-use bubble), srai
    add(1,1,c_addi,32'h100,0,1,0,     1,1,1,3'd7, 1,0,0,0,0,0,0, 0);
    add(1,1,c_lw,32'h104,0,1,5,       1,1,1,3'd0, 1,1,c_addi,32'h100,5,1,0, 0);
    add(1,1,c_add,32'h108,0,1,0,      1,1,1,3'd0, 1,1,c_lw,32'h104,0,5,1, 0);
    add(1,1,c_srai,32'h10C,0,1,0,     1,0,1,3'd7, 0,0,0,0,0,0,0, 1);
    add(1,1,c_srai,32'h10C,0,1,0,     1,1,1,3'd7, 1,1,c_add,32'h108,0,6,0, 1);
    add(1,1,c_slli,32'h110,0,1,32'h407, 1,1,1,3'd6, 1,1,c_srai,32'h10C,32'h407,3,0, 1);
    // three cycles of back-pressure with both stages valid
    for (int k = 0; k < 3; k++)
      add(1,1,c_lui,32'h114,0,0,1,    1,0,1,3'd5, 1,1,c_srai,32'h10C,32'h407,3,0, 1);
    add(1,1,c_lui,32'h114,0,1,1,      1,1,1,3'd5, 1,1,c_slli,32'h110,1,1,0, 1);
    add(1,1,c_jal,32'h118,0,1,32'h12345000, 1,1,1,3'd3, 1,1,c_lui,32'h114,32'h12345000,7,0, 1);
    add(1,1,c_lw,32'h11C,0,1,0,       1,1,1,3'd4, 1,1,c_jal,32'h118,0,0,0, 1);
    add(1,1,c_add,32'h120,0,1,0,      1,1,1,3'd0, 1,1,c_lw,32'h11C,0,5,1, 1);
    // load-use while EX is stalled: bubble waits for ex_ready
    add(1,1,c_sw,32'h124,0,0,0,       1,0,1,3'd7, 1,1,c_lw,32'h11C,0,5,1, 1);
    add(1,1,c_sw,32'h124,0,1,0,       1,0,1,3'd7, 0,0,0,0,0,0,0, 2);
    add(1,1,c_sw,32'h124,0,1,0,       1,1,1,3'd7, 1,1,c_add,32'h120,0,6,0, 2);
    // flush with both stages valid; beq re-presented afterwards
    add(1,1,c_beq,32'h128,1,1,0,      1,0,1,3'd1, 0,0,0,0,0,0,0, 2);
    add(1,1,c_beq,32'h128,0,1,0,      1,1,0,3'd0, 0,0,0,0,0,0,0, 2);
    add(1,0,0,0,0,1,0,                1,1,1,3'd2, 1,1,c_beq,32'h128,0,0,0, 2);
    // flush coinciding with hazard and ex_ready=0
    add(1,1,c_lw,32'h200,0,1,0,       1,1,0,3'd0, 0,0,0,0,0,0,0, 2);
    add(1,1,c_add,32'h204,0,1,0,      1,1,1,3'd0, 1,1,c_lw,32'h200,0,5,1, 2);
    add(1,1,c_srai,32'h208,1,0,0,     1,0,1,3'd7, 0,0,0,0,0,0,0, 2);
    add(1,0,0,0,0,1,0,                1,1,0,3'd0, 0,0,0,0,0,0,0, 2);
    // reset asserted mid-stall
    add(1,1,c_lw,32'h300,0,1,0,       1,1,0,3'd0, 0,0,0,0,0,0,0, 2);
    add(1,1,c_add,32'h304,0,1,0,      1,1,1,3'd0, 1,1,c_lw,32'h300,0,5,1, 2);
    add(0,1,c_srai,32'h308,0,1,0,     1,0,1,3'd7, 1,0,0,0,0,0,0, 0);
    add(1,0,0,0,0,1,0,                1,1,1,3'd7, 1,0,0,0,0,0,0, 0);
    // load to x0 never causes a hazard
    add(1,1,c_lw0,32'h400,0,1,0,      1,1,1,3'd7, 1,0,0,0,0,0,0, 0);
    add(1,1,c_add0,32'h404,0,1,0,     1,1,1,3'd0, 1,1,c_lw0,32'h400,0,0,1, 0);
    add(1,0,0,0,0,1,0,                1,1,1,3'd7, 1,1,c_add0,32'h404,0,6,0, 0);

    foreach (vq[i]) begin
      rst_n = vq[i].rst_n; if_valid = vq[i].if_valid; if_instr = vq[i].if_instr;
      if_pc = vq[i].if_pc; flush = vq[i].flush; ex_ready = vq[i].ex_ready;
      imm_in = vq[i].imm_in;
      #1;
      if (vq[i].chk_comb) chk("id_ready", i, {31'd0, id_ready}, {31'd0, vq[i].e_id_ready});
      if (vq[i].chk_sel)  chk("imm_sel", i, {29'd0, imm_sel}, {29'd0, vq[i].e_imm_sel});
      @(posedge clk); #1;
      chk("ex_valid", i, {31'd0, ex_valid}, {31'd0, vq[i].e_valid});
      if (vq[i].chk_data) begin
        chk("ex_instr", i, ex_instr, vq[i].e_instr);
        chk("ex_pc", i, ex_pc, vq[i].e_pc);
        chk("ex_imm", i, ex_imm, vq[i].e_imm);
        chk("ex_rd", i, {27'd0, ex_rd}, {27'd0, vq[i].e_rd});
        chk("ex_is_load", i, {31'd0, ex_is_load}, {31'd0, vq[i].e_load});
      end
`ifdef ID_STALL_CNT_EN
      chk("stall_cnt", i, stall_cnt, vq[i].e_stall);
`endif
    end

    // imm_sel decode sweep: srli, andi, jalr, fence, auipc
    sweep_i[0] = 32'h0010D093; sweep_s[0] = 3'b101;
    sweep_i[1] = 32'h0010F093; sweep_s[1] = 3'b000;
    sweep_i[2] = 32'h00008067; sweep_s[2] = 3'b000;
    sweep_i[3] = 32'h0000000F; sweep_s[3] = 3'b111;
    sweep_i[4] = 32'h00000097; sweep_s[4] = 3'b011;
    rst_n = 1'b1; flush = 1'b0; ex_ready = 1'b1; imm_in = '0;
    for (int k = 0; k < 5; k++) begin
      if_valid = 1'b1; if_instr = sweep_i[k]; if_pc = 32'h500 + 32'(k * 4);
      @(posedge clk); #1;
      chk("sweep_imm_sel", 100 + k, {29'd0, imm_sel}, {29'd0, sweep_s[k]});
      chk("sweep_id_ready", 100 + k, {31'd0, id_ready}, 32'd1);
    end
    if_valid = 1'b0;
    @(posedge clk); #1;
    chk("sweep_last_pc", 105, ex_pc, 32'h510);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
